// File: rtl/sram_fifo_ctrl.sv
// SRAM-backed FIFO: 1R1W SRAM plus a 3-entry output buffer; enq at edge T shows deq_valid after edge T+2.
// Backpressure: enq_ready is registered from next occupancy; SRAM reads stall while buffer+in-flight reaches 3.
module sram_fifo_ctrl #(
  parameter  int WIDTH  = 96,
  parameter  int DEPTH  = 128,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enq_valid,
  output logic                enq_ready,
  input  logic [WIDTH-1:0]    enq_bits,
  output logic                deq_valid,
  input  logic                deq_ready,
  output logic [WIDTH-1:0]    deq_bits,
  output logic [ADDR_W:0]     count,
  output logic [ADDR_W-1:0]   sram_a1,
  output logic                sram_csb1,
  output logic                sram_oeb1,
  input  logic [WIDTH-1:0]    sram_o1,
  output logic [ADDR_W-1:0]   sram_a2,
  output logic                sram_csb2,
  output logic                sram_web2,
  output logic [WIDTH/8-1:0]  sram_wbm2,
  output logic [WIDTH-1:0]    sram_i2
);

  localparam int BUF_N = 3;

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   sram_cnt_q, sram_cnt_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [1:0]        buf_cnt_q, buf_cnt_d;
  logic              rd_inflight_q, rd_inflight_d;
  logic              enq_ready_q, enq_ready_d;
  logic              deq_valid_q, deq_valid_d;
  logic [WIDTH-1:0]  buf_q [BUF_N];
  logic [WIDTH-1:0]  buf_d [BUF_N];

  logic              enq_fire;
  logic              deq_fire;
  logic              rd_issue;
  logic [2:0]        occ;
  logic [1:0]        tail_idx;

  always_comb begin
    enq_fire      = enq_valid & enq_ready_q;
    deq_fire      = deq_valid_q & deq_ready;
    // Reserve a buffer slot for every read still in flight so a capture never overflows.
    occ           = {1'b0, buf_cnt_q} + {2'b00, rd_inflight_q};
    rd_issue      = (sram_cnt_q != '0) && (occ < 3'(BUF_N));

    wr_ptr_d      = wr_ptr_q + ADDR_W'(enq_fire);
    rd_ptr_d      = rd_ptr_q + ADDR_W'(rd_issue);
    sram_cnt_d    = sram_cnt_q + (ADDR_W+1)'(enq_fire) - (ADDR_W+1)'(rd_issue);
    count_d       = count_q + (ADDR_W+1)'(enq_fire) - (ADDR_W+1)'(deq_fire);
    enq_ready_d   = count_d < (ADDR_W+1)'(DEPTH);
    rd_inflight_d = rd_issue;

    buf_d = buf_q;
    if (deq_fire) begin
      for (int i = 0; i < BUF_N - 1; i++) begin
        buf_d[i] = buf_q[i+1];
      end
    end
    tail_idx = buf_cnt_q - {1'b0, deq_fire};
    if (rd_inflight_q) begin
      buf_d[tail_idx] = sram_o1;
    end
    buf_cnt_d   = buf_cnt_q + {1'b0, rd_inflight_q} - {1'b0, deq_fire};
    deq_valid_d = (buf_cnt_d != 2'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      sram_cnt_q    <= '0;
      count_q       <= '0;
      buf_cnt_q     <= '0;
      rd_inflight_q <= 1'b0;
      enq_ready_q   <= 1'b0;
      deq_valid_q   <= 1'b0;
      for (int i = 0; i < BUF_N; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      sram_cnt_q    <= sram_cnt_d;
      count_q       <= count_d;
      buf_cnt_q     <= buf_cnt_d;
      rd_inflight_q <= rd_inflight_d;
      enq_ready_q   <= enq_ready_d;
      deq_valid_q   <= deq_valid_d;
      for (int i = 0; i < BUF_N; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

  assign enq_ready = enq_ready_q;
  assign deq_valid = deq_valid_q;
  assign deq_bits  = buf_q[0];
  assign count     = count_q;

  assign sram_a1   = rd_ptr_q;
  assign sram_csb1 = ~rd_issue;
  assign sram_oeb1 = 1'b0;
  assign sram_a2   = wr_ptr_q;
  assign sram_csb2 = ~enq_fire;
  assign sram_web2 = ~enq_fire;
  assign sram_wbm2 = '1;
  assign sram_i2   = enq_bits;

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Bench for sram_fifo_ctrl: SRAM macro model, queue-based scoreboard, vector table and corner sequences.
module tb_sram_fifo_ctrl;

  localparam int W = 96;
  localparam int D = 128;

  logic          clk;
  logic          reset_n;
  logic          enq_valid;
  logic          enq_ready;
  logic [W-1:0]  enq_bits;
  logic          deq_valid;
  logic          deq_ready;
  logic [W-1:0]  deq_bits;
  logic [7:0]    count;
  logic [6:0]    sram_a1;
  logic          sram_csb1;
  logic          sram_oeb1;
  logic [W-1:0]  sram_o1;
  logic [6:0]    sram_a2;
  logic          sram_csb2;
  logic          sram_web2;
  logic [W/8-1:0] sram_wbm2;
  logic [W-1:0]  sram_i2;

  int total = 0;
  int bad   = 0;

  sram_fifo_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset_n(reset_n),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_bits(enq_bits),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_bits(deq_bits),
    .count(count),
    .sram_a1(sram_a1), .sram_csb1(sram_csb1), .sram_oeb1(sram_oeb1), .sram_o1(sram_o1),
    .sram_a2(sram_a2), .sram_csb2(sram_csb2), .sram_web2(sram_web2),
    .sram_wbm2(sram_wbm2), .sram_i2(sram_i2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM macro: both ports registered on the clock edge, byte-masked writes.
  logic [W-1:0] mem [D];
  always @(posedge clk) begin
    if (!sram_csb2 && !sram_web2) begin
      for (int b = 0; b < W/8; b++) begin
        if (sram_wbm2[b]) mem[sram_a2][b*8 +: 8] <= sram_i2[b*8 +: 8];
      end
    end
    if (!sram_csb1) sram_o1 <= mem[sram_a1];
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: words accepted but not yet delivered, words still in SRAM,
  // and reads issued but not yet delivered (buffer plus in-flight).
  logic [W-1:0] q [$];
  int           m_sram;
  int           m_out;
  bit           m_prev_rd;
  logic [6:0]   m_rd_addr;
  logic [6:0]   m_wr_addr;
  bit           armed;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) armed <= 1'b0;
    else          armed <= 1'b1;
  end

  always @(negedge clk) begin : monitor
    bit exp_rd;
    bit e_f;
    bit d_f;
    int bufn;
    if (!reset_n) begin
      q.delete();
      m_sram    = 0;
      m_out     = 0;
      m_prev_rd = 1'b0;
      m_rd_addr = '0;
      m_wr_addr = '0;
    end else begin
      exp_rd = (m_sram > 0) && (m_out < 3);
      bufn   = m_out - (m_prev_rd ? 1 : 0);
      e_f    = enq_valid && enq_ready;
      d_f    = deq_valid && deq_ready;
      chk("mon_count", W'(count), W'(q.size()));
      chk("mon_enq_ready", W'(enq_ready), W'(armed && (q.size() < D)));
      chk("mon_deq_valid", W'(deq_valid), W'(bufn > 0));
      chk("mon_rd_issue", W'(!sram_csb1), W'(exp_rd));
      if (exp_rd) chk("mon_rd_addr", W'(sram_a1), W'(m_rd_addr));
      chk("mon_wr_strobe", W'({sram_csb2, sram_web2}), e_f ? W'(0) : W'(3));
      chk("mon_oeb1", W'(sram_oeb1), W'(0));
      if (d_f) begin
        if (q.size() == 0) chk("mon_deq_empty", W'(1), W'(0));
        else chk("mon_deq_bits", deq_bits, q.pop_front());
      end
      if (e_f) begin
        chk("mon_wr_addr", W'(sram_a2), W'(m_wr_addr));
        chk("mon_wr_data", sram_i2, enq_bits);
        chk("mon_wr_mask", W'(sram_wbm2), W'(12'hFFF));
        q.push_back(enq_bits);
      end
      m_sram    = m_sram + (e_f ? 1 : 0) - (exp_rd ? 1 : 0);
      m_out     = m_out + (exp_rd ? 1 : 0) - (d_f ? 1 : 0);
      m_prev_rd = exp_rd;
      m_rd_addr = m_rd_addr + (exp_rd ? 7'd1 : 7'd0);
      m_wr_addr = m_wr_addr + (e_f ? 7'd1 : 7'd0);
    end
  end

  typedef struct {
    logic       ev;
    logic [7:0] eb;
    logic       dr;
    logic       xdv;
    logic [7:0] xcnt;
    logic       xer;
    logic       xcsb1;
    logic       xcsb2;
    logic       cb;
    logic [7:0] xb;
  } vec_t;

  vec_t tbl [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] fw(int i);
    return {32'hF111F111, 32'h0, 32'(i)};
  endfunction

  initial begin
    int n, got, cyc, first, sent;
    bit found;
    logic [W-1:0] first_word;

    // cycle-by-cycle vectors from a fresh reset: inputs, then expected outputs
    tbl[0] = '{1'b1, 8'hA1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 8'hA2, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'd2, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA1};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'd2, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA1};
    tbl[5] = '{1'b1, 8'hA3, 1'b1, 1'b1, 8'd1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA2};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'd1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'd1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'd1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA3};
    tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};

    reset_n   = 1'b1;
    enq_valid = 1'b0;
    enq_bits  = '0;
    deq_ready = 1'b0;
    #2 reset_n = 1'b0;
    #2;
    chk("rst_count", W'(count), W'(0));
    chk("rst_enq_ready", W'(enq_ready), W'(0));
    chk("rst_deq_valid", W'(deq_valid), W'(0));
    chk("rst_deq_bits", deq_bits, W'(0));
    chk("rst_csb1", W'(sram_csb1), W'(1));
    chk("rst_csb2", W'(sram_csb2), W'(1));
    chk("rst_web2", W'(sram_web2), W'(1));
    @(negedge clk);
    #1 reset_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      enq_valid = tbl[i].ev;
      enq_bits  = {12{tbl[i].eb}};
      deq_ready = tbl[i].dr;
      @(negedge clk);
      chk($sformatf("vec%0d_deq_valid", i), W'(deq_valid), W'(tbl[i].xdv));
      chk($sformatf("vec%0d_count", i), W'(count), W'(tbl[i].xcnt));
      chk($sformatf("vec%0d_enq_ready", i), W'(enq_ready), W'(tbl[i].xer));
      chk($sformatf("vec%0d_csb1", i), W'(sram_csb1), W'(tbl[i].xcsb1));
      chk($sformatf("vec%0d_csb2", i), W'(sram_csb2), W'(tbl[i].xcsb2));
      if (tbl[i].cb) chk($sformatf("vec%0d_deq_bits", i), deq_bits, {12{tbl[i].xb}});
      tick();
    end

    // single word latency
    enq_valid = 1'b1;
    enq_bits  = {12{8'hA5}};
    deq_ready = 1'b1;
    tick();
    enq_valid = 1'b0;
    @(negedge clk);
    chk("single_dv_t0", W'(deq_valid), W'(0));
    tick();
    @(negedge clk);
    chk("single_dv_t1", W'(deq_valid), W'(0));
    tick();
    @(negedge clk);
    chk("single_dv_t2", W'(deq_valid), W'(1));
    chk("single_bits", deq_bits, {12{8'hA5}});
    tick();
    @(negedge clk);
    chk("single_count", W'(count), W'(0));
    tick();

    // fill to full, refuse the extra word, then enq+deq together while full
    deq_ready = 1'b0;
    n = 0;
    cyc = 0;
    while (n < D && cyc < 400) begin
      enq_valid = 1'b1;
      enq_bits  = fw(n);
      @(negedge clk);
      if (enq_ready) n++;
      tick();
      cyc++;
    end
    enq_bits = fw(999);
    @(negedge clk);
    chk("full_count", W'(count), W'(D));
    chk("full_enq_ready", W'(enq_ready), W'(0));
    tick();
    tick();
    @(negedge clk);
    chk("full_refused_count", W'(count), W'(D));
    tick();
    deq_ready = 1'b1;
    tick();
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    @(negedge clk);
    chk("full_simul_count", W'(count), W'(D - 1));
    chk("full_simul_enq_ready", W'(enq_ready), W'(1));
    tick();
    deq_ready = 1'b1;
    got = 0;
    cyc = 0;
    first_word = '0;
    while (got < D - 1 && cyc < 600) begin
      @(negedge clk);
      if (deq_valid) begin
        if (got == 0) first_word = deq_bits;
        got++;
      end
      tick();
      cyc++;
    end
    chk("fill_drained", W'(got), W'(D - 1));
    chk("fill_first_after_simul", first_word, fw(1));
    @(negedge clk);
    chk("fill_empty", W'(count), W'(0));
    tick();

    // streaming: 300 back-to-back words
    sent = 0;
    got = 0;
    cyc = 0;
    first = -1;
    deq_ready = 1'b1;
    while (got < 300 && cyc < 1000) begin
      enq_valid = (sent < 300);
      enq_bits  = {$urandom, $urandom, $urandom};
      @(negedge clk);
      if (enq_valid && enq_ready) sent++;
      if (deq_valid) begin
        if (first < 0) first = cyc;
        got++;
      end
      tick();
      cyc++;
    end
    enq_valid = 1'b0;
    chk("stream_got", W'(got), W'(300));
    chk("stream_no_bubbles", W'(cyc - first), W'(300));

    // backpressure: 30% consumer duty
    sent = 0;
    got = 0;
    cyc = 0;
    while (got < 1000 && cyc < 20000) begin
      enq_valid = (sent < 1000) && ($urandom_range(0, 99) < 80);
      enq_bits  = {$urandom, $urandom, $urandom};
      deq_ready = ($urandom_range(0, 99) < 30);
      @(negedge clk);
      if (enq_valid && enq_ready) sent++;
      if (deq_valid && deq_ready) got++;
      tick();
      cyc++;
    end
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    chk("bp_got", W'(got), W'(1000));

    // mid-operation reset with 50 queued and a read in flight
    n = 0;
    cyc = 0;
    while (n < 50 && cyc < 200) begin
      enq_valid = 1'b1;
      enq_bits  = fw(5000 + n);
      @(negedge clk);
      if (enq_ready) n++;
      tick();
      cyc++;
    end
    enq_valid = 1'b0;
    deq_ready = 1'b1;
    tick();
    deq_ready = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (!sram_csb1) found = 1'b1;
    end
    chk("rst_mid_read_seen", W'(found), W'(1));
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_count", W'(count), W'(0));
    chk("rst_mid_deq_valid", W'(deq_valid), W'(0));
    chk("rst_mid_deq_bits", deq_bits, W'(0));
    chk("rst_mid_enq_ready", W'(enq_ready), W'(0));
    chk("rst_mid_csb1", W'(sram_csb1), W'(1));
    @(negedge clk);
    #1 reset_n = 1'b1;
    tick();
    enq_valid = 1'b1;
    enq_bits  = {12{8'h5A}};
    @(negedge clk);
    chk("rst_mid_enq_ready_up", W'(enq_ready), W'(1));
    tick();
    enq_valid = 1'b0;
    deq_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (deq_valid) found = 1'b1;
      else tick();
    end
    chk("rst_mid_dv_seen", W'(found), W'(1));
    chk("rst_mid_first_word", deq_bits, {12{8'h5A}});
    tick();
    deq_ready = 1'b0;
    @(negedge clk);
    chk("rst_mid_final_count", W'(count), W'(0));
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_fifo_ctrl.md
SRAM_FIFO_CTRL -- requirements
Module: sram_fifo_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, 96, data word width in bits.
REQ-002 SHALL have parameter DEPTH, 128, number of SRAM entries; ADDR_W = log2(DEPTH) = 7.
REQ-003 SHALL have port clk  in  1  single clock; the parent ties SRAM CE1 and CE2 to clk.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port enq_valid  in  1  producer offers a word.
REQ-006 SHALL have port enq_ready  out  1  controller can accept a word.
REQ-007 SHALL have port enq_bits  in  WIDTH  word to enqueue.
REQ-008 SHALL have port deq_valid  out  1  head word is available.
REQ-009 SHALL have port deq_ready  in  1  consumer takes the head word.
REQ-010 SHALL have port deq_bits  out  WIDTH  head word.
REQ-011 SHALL have port count  out  ADDR_W+1  total occupancy: SRAM entries plus in-flight read plus output buffer.
REQ-012 SHALL have port sram_a1, sram_csb1, sram_oeb1  out  7/1/1  SRAM read-port address, active-low chip select, active-low output enable.
REQ-013 SHALL have port sram_o1  in  WIDTH  SRAM read data, registered inside the macro at the clk edge where csb1=0.
REQ-014 SHALL have port sram_a2, sram_csb2, sram_web2, sram_wbm2, sram_i2  out  7/1/1/WIDTH/8/WIDTH  SRAM write-port address, chip select, write enable, byte mask, data.

Function
REQ-015 A transfer SHALL occur only on a clk edge with valid=1 and ready=1 (enq_fire, deq_fire).
REQ-016 On enq_fire, the same cycle SHALL drive sram_csb2=0, sram_web2=0, sram_a2=wr_ptr, sram_i2=enq_bits and sram_wbm2 all ones; the edge SHALL advance wr_ptr by 1, modulo DEPTH.
REQ-017 When there is no enq_fire, the controller SHALL drive sram_csb2=1 and sram_web2=1.
REQ-018 sram_oeb1 SHALL be constant 0.
REQ-019 The controller SHALL hold an output buffer of 3 entries, a 1-bit rd_inflight flag and sram_cnt (entries written and not yet read-issued).
REQ-020 The controller SHALL issue a read (sram_csb1=0, sram_a1=rd_ptr) in a cycle only when sram_cnt>0 and buf_cnt+rd_inflight<3; the edge SHALL advance rd_ptr modulo DEPTH and set rd_inflight.
REQ-021 In any cycle without a read issue, sram_csb1 SHALL be 1.
REQ-022 A word written at edge T SHALL first be readable by a read issued in the cycle after T; a read and a write to the same address on one edge SHALL NOT occur.
REQ-023 In the cycle after a read edge, the controller SHALL capture sram_o1 into the buffer tail at the next edge; rd_inflight SHALL clear unless a new read is issued in the same cycle.
REQ-024 deq_valid SHALL equal (buf_cnt>0); deq_bits SHALL be the buffer head; both SHALL come from registers only.
REQ-025 Ordering SHALL be strict FIFO; every accepted word is delivered exactly once.
REQ-026 Latency SHALL be: a word accepted at edge T into an empty controller gives deq_valid=1 in the cycle following edge T+2.
REQ-027 Throughput SHALL be sustained at one enq and one deq per cycle indefinitely once the pipeline is primed.
REQ-028 count SHALL update each edge by +enq_fire -deq_fire.
REQ-029 enq_ready SHALL be a register equal to (next count < DEPTH); when full, enq is refused even with a simultaneous deq.
REQ-030 Pointers SHALL wrap from 127 to 0 with no loss or duplication.
REQ-031 Capture and deq on the same edge SHALL leave buf_cnt unchanged and preserve order.

Reset
REQ-032 While reset_n=0, all registers SHALL clear immediately: pointers=0, sram_cnt=0, buf_cnt=0, rd_inflight=0, count=0, enq_ready=0, deq_valid=0, deq_bits=0.
REQ-033 While reset_n=0, the SRAM controls SHALL be inactive: sram_csb1=1, sram_csb2=1, sram_web2=1.
REQ-034 enq_ready SHALL rise at the first clk edge after reset_n deasserts.
REQ-035 SRAM contents SHALL NOT be cleared; an in-flight read during reset SHALL be discarded.

Verification
REQ-036 Single word: enq 0xA5 repeated across 96 bits at edge T, deq_ready=1 -> deq_valid=1 after edge T+2, deq_bits matches, count returns to 0.
REQ-037 Fill: 128 enqs with deq_ready=0 -> enq_ready=0 and count=128; the 129th offer is not accepted; deqs then return words 0..127 in order.
REQ-038 Streaming: 300 back-to-back words with enq_valid=deq_ready=1 -> after priming, one deq per cycle with no bubbles, and the pointers wrap twice with no data error.
REQ-039 Backpressure: random deq_ready at 30% duty for 1000 words -> no SRAM read issued while buf_cnt+rd_inflight=3, and order is preserved.
REQ-040 Full plus simultaneous: with count=128, enq_valid=1 and deq_ready=1 on the same cycle -> deq occurs, enq is refused, count=127, and enq_ready=1 on the next cycle.
REQ-041 Mid-operation reset: reset_n pulsed low with 50 words queued and a read in flight -> outputs clear immediately, count=0, and the first post-reset enq word is the first word delivered.
